ahb_lite_word_master: RTL and testbench

AHB-lite bus master that turns a simple command handshake into word-sized AHB-lite transfers (single or incrementing burst of 1–16 beats) on the system bus. It drives AHB slaves such as the on-chip SRAM bridge. It fully pipelines address and data phases, honours slave wait states, splits bursts at 1 KB boundaries, and aborts on an ERROR response.

---
 rtl/ahb_lite_word_master_if.sv | 35 +++
 rtl/ahb_lite_word_master.sv | 95 +++++++++
 tb/tb_ahb_lite_word_master.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_word_master_if.sv
// ahb_lite_word_master_if: command, write-FIFO, read-data and AHB-lite master signal bundle
interface ahb_lite_word_master_if;
  logic        I_CMD_VALID;
  logic        O_CMD_READY;
  logic        I_CMD_WRITE;
  logic [31:0] I_CMD_ADDR;
  logic [3:0]  I_CMD_LEN;
  logic [31:0] I_WDATA;
  logic        O_WPOP;
  logic [31:0] O_RDATA;
  logic        O_RDATA_VALID;
  logic        O_DONE;
  logic        O_ERR;
  logic [31:0] O_HADDR;
  logic [1:0]  O_HTRANS;
  logic        O_HWRITE;
  logic [2:0]  O_HSIZE;
  logic [2:0]  O_HBURST;
  logic [3:0]  O_HPROT;
  logic        O_HMASTLOCK;
  logic [31:0] O_HWDATA;
  logic [31:0] I_HRDATA;
  logic        I_HREADY;
  logic        I_HRESP;
  modport master (
    input  I_CMD_VALID, I_CMD_WRITE, I_CMD_ADDR, I_CMD_LEN, I_WDATA, I_HRDATA, I_HREADY, I_HRESP,
    output O_CMD_READY, O_WPOP, O_RDATA, O_RDATA_VALID, O_DONE, O_ERR, O_HADDR, O_HTRANS,
           O_HWRITE, O_HSIZE, O_HBURST, O_HPROT, O_HMASTLOCK, O_HWDATA
  );
  modport slave (
    output I_CMD_VALID, I_CMD_WRITE, I_CMD_ADDR, I_CMD_LEN, I_WDATA, I_HRDATA, I_HREADY, I_HRESP,
    input  O_CMD_READY, O_WPOP, O_RDATA, O_RDATA_VALID, O_DONE, O_ERR, O_HADDR, O_HTRANS,
           O_HWRITE, O_HSIZE, O_HBURST, O_HPROT, O_HMASTLOCK, O_HWDATA
  );
endinterface

// File: rtl/ahb_lite_word_master.sv
// ahb_lite_word_master: command handshake to pipelined word AHB-lite single/INCR bursts
module ahb_lite_word_master (
  input logic                    I_HCLK,
  input logic                    I_HRESETn,
  ahb_lite_word_master_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BURST, S_LAST, S_ERR, S_DONE} state_t;
  state_t      r_state;
  logic [31:0] r_haddr, r_hwdata;
  logic [1:0]  r_htrans;
  logic [4:0]  r_addr_left, r_data_left;
  logic        r_hwrite, r_hburst, r_dphase, r_done, r_err;
  logic        w_err, w_cancel, w_a_acc, w_d_done;
  logic [31:0] w_next_addr;
  assign w_err       = r_dphase & bus.I_HRESP;
  assign w_cancel    = w_err & ~bus.I_HREADY;
  assign w_a_acc     = r_htrans[1] & bus.I_HREADY & ~w_err;
  assign w_d_done    = r_dphase & bus.I_HREADY & ~bus.I_HRESP;
  assign w_next_addr = r_haddr + 32'd4;
  assign bus.O_CMD_READY   = r_state == S_IDLE;
  assign bus.O_HTRANS      = w_cancel ? 2'b00 : r_htrans;
  assign bus.O_HADDR       = r_haddr;
  assign bus.O_HWRITE      = r_hwrite;
  assign bus.O_HSIZE       = 3'b010;
  assign bus.O_HBURST      = {2'b00, r_hburst};
  assign bus.O_HPROT       = 4'b0011;
  assign bus.O_HMASTLOCK   = 1'b0;
  assign bus.O_HWDATA      = r_hwdata;
  assign bus.O_WPOP        = w_a_acc & r_hwrite;
  assign bus.O_RDATA       = bus.I_HRDATA;
  assign bus.O_RDATA_VALID = w_d_done & ~r_hwrite;
  assign bus.O_DONE        = r_done;
  assign bus.O_ERR         = r_err;
  always_ff @(posedge I_HCLK or negedge I_HRESETn)
    if (!I_HRESETn) begin
      r_state     <= S_IDLE;
      r_haddr     <= '0;
      r_hwdata    <= '0;
      r_htrans    <= 2'b00;
      r_addr_left <= '0;
      r_data_left <= '0;
      r_hwrite    <= 1'b0;
      r_hburst    <= 1'b0;
      r_dphase    <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else
      case (r_state)
        S_IDLE:
          if (bus.I_CMD_VALID) begin
            r_state     <= S_ADDR;
            r_hwrite    <= bus.I_CMD_WRITE;
            r_haddr     <= {bus.I_CMD_ADDR[31:2], 2'b00};
            r_htrans    <= 2'b10;
            r_hburst    <= |bus.I_CMD_LEN;
            r_addr_left <= {1'b0, bus.I_CMD_LEN} + 5'd1;
            r_data_left <= {1'b0, bus.I_CMD_LEN} + 5'd1;
            r_dphase    <= 1'b0;
          end
        S_ERR: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
          r_err   <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
        end
        default:
          if (w_err) begin
            r_state  <= S_ERR;
            r_htrans <= 2'b00;
            r_dphase <= 1'b0;
          end else begin
            // a new 1 KB page must restart with NONSEQ
            if (w_a_acc) begin
              r_addr_left <= r_addr_left - 5'd1;
              r_haddr     <= w_next_addr;
              r_htrans    <= r_addr_left == 5'd1 ? 2'b00 : w_next_addr[9:0] == 10'd0 ? 2'b10 : 2'b11;
              r_state     <= r_addr_left == 5'd1 ? S_LAST : S_BURST;
            end
            if (w_a_acc & r_hwrite) r_hwdata <= bus.I_WDATA;
            if (w_a_acc | w_d_done) r_dphase <= w_a_acc;
            if (w_d_done) begin
              r_data_left <= r_data_left - 5'd1;
              if (r_data_left == 5'd1) begin
                r_state  <= S_DONE;
                r_done   <= 1'b1;
                r_htrans <= 2'b00;
              end
            end
          end
      endcase
endmodule

// File: tb/tb_ahb_lite_word_master.sv
// tb_ahb_lite_word_master: directed commands against a scripted slave with a cycle-stamped scoreboard
module tb_ahb_lite_word_master;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  ahb_lite_word_master_if bus();
  ahb_lite_word_master dut (.I_HCLK(clk), .I_HRESETn(rst_n), .bus(bus));
  typedef enum int {K_ADDR, K_RDV, K_POP, K_WD, K_DONE, K_RDY} kind_t;
  typedef struct {int c; kind_t k; logic [39:0] v;} ev_t;
  ev_t q[$];
  int checks = 0, errors = 0, cyc = 0, t0 = -100, widx = 0, r = 0;
  int stall_lo = -10, stall_hi = -10, err_off = -10;
  logic [31:0] wfifo [0:7];
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.O_WPOP) widx <= widx + 1;
  assign bus.I_WDATA = wfifo[widx[2:0]];

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", n, cyc + 1, act, exp);
    end
  endtask

  task automatic ex(input int c, input kind_t k, input logic [39:0] v);
    q.push_back('{c, k, v});
  endtask

  function automatic logic [39:0] av(input logic [2:0] b, input logic [1:0] t, input logic [31:0] a);
    return {3'b000, b, t, a};
  endfunction

  // scripted slave: offsets relative to the acceptance edge of the current command
  initial forever begin
    @(posedge clk);
    #1;
    r = cyc + 1 - t0;
    bus.I_HREADY = !((r >= stall_lo && r <= stall_hi) || r == err_off);
    bus.I_HRESP  = (r == err_off || r == err_off + 1);
    bus.I_HRDATA = 32'hCAFE_0000 + 32'(r - 1);
  end

  task automatic mon();
    int now;
    bit sr, sp, sd, sa;
    now = cyc + 1;
    sr = 0; sp = 0; sd = 0; sa = 0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].c == now) begin
        case (q[i].k)
          K_ADDR: begin sa = 1; chk("addr_phase", {bus.O_HBURST, bus.O_HTRANS, bus.O_HADDR}, q[i].v[36:0]); end
          K_RDV:  begin sr = 1; chk("rdata", bus.O_RDATA, q[i].v[31:0]); end
          K_POP:  sp = 1;
          K_WD:   chk("hwdata", bus.O_HWDATA, q[i].v[31:0]);
          K_DONE: begin sd = 1; chk("err_flag", bus.O_ERR, q[i].v[0]); end
          default: chk("cmd_ready", bus.O_CMD_READY, q[i].v[0]);
        endcase
        q.delete(i);
      end
    chk("rdata_valid", bus.O_RDATA_VALID, sr);
    chk("wpop", bus.O_WPOP, sp);
    chk("done", bus.O_DONE, sd);
    chk("unexpected_xfer", bus.O_HTRANS[1] & bus.I_HREADY & !sa, 0);
  endtask

  initial forever begin
    @(negedge clk);
    mon();
  end

  task automatic issue(input bit w, input logic [31:0] a, input logic [3:0] l);
    chk("ready_before_cmd", bus.O_CMD_READY, 1);
    bus.I_CMD_VALID = 1'b1;
    bus.I_CMD_WRITE = w;
    bus.I_CMD_ADDR  = a;
    bus.I_CMD_LEN   = l;
    t0 = cyc + 1;
    @(posedge clk);
    #1;
    bus.I_CMD_VALID = 1'b0;
  endtask

  task automatic wait_done();
    bit got;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      #1;
      got = bus.O_DONE;
    end
    chk("done_seen", got, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.I_CMD_VALID = 0; bus.I_CMD_WRITE = 0; bus.I_CMD_ADDR = 0; bus.I_CMD_LEN = 0;
    bus.I_HREADY = 1; bus.I_HRESP = 0; bus.I_HRDATA = 0;
    wfifo[0] = 32'hA0; wfifo[1] = 32'hA1; wfifo[2] = 32'hA2; wfifo[3] = 32'hA3;
    wfifo[4] = 32'hB0; wfifo[5] = 32'hB1; wfifo[6] = 32'hC0; wfifo[7] = 32'hDEAD;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_htrans", bus.O_HTRANS, 0);
    chk("rst_haddr", bus.O_HADDR, 0);
    chk("rst_hwdata", bus.O_HWDATA, 0);
    chk("rst_hwrite", bus.O_HWRITE, 0);
    chk("rst_hburst", bus.O_HBURST, 0);
    chk("rst_done_err", {bus.O_DONE, bus.O_ERR}, 0);
    chk("rst_pop_rdv", {bus.O_WPOP, bus.O_RDATA_VALID}, 0);
    chk("rst_ready", bus.O_CMD_READY, 1);
    chk("const_size_prot_lock", {bus.O_HSIZE, bus.O_HPROT, bus.O_HMASTLOCK}, {3'b010, 4'b0011, 1'b0});
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // single read, unaligned address
    issue(0, 32'h0000_0103, 4'd0);
    ex(t0 + 1, K_ADDR, av(3'b000, 2'b10, 32'h100));
    ex(t0 + 1, K_RDY, 0);
    ex(t0 + 2, K_RDV, 32'hCAFE_0001);
    ex(t0 + 3, K_DONE, 0);
    ex(t0 + 3, K_RDY, 0);
    wait_done();
    // 4-beat write burst
    issue(1, 32'h20, 4'd3);
    for (int i = 0; i < 4; i++) begin
      ex(t0 + 1 + i, K_ADDR, av(3'b001, i == 0 ? 2'b10 : 2'b11, 32'h20 + 32'(4 * i)));
      ex(t0 + 1 + i, K_POP, 0);
      ex(t0 + 2 + i, K_WD, 32'hA0 + 32'(i));
    end
    ex(t0 + 6, K_DONE, 0);
    wait_done();
    // 3-beat read with two wait states on beat 1
    stall_lo = 3; stall_hi = 4;
    issue(0, 32'h40, 4'd2);
    ex(t0 + 1, K_ADDR, av(3'b001, 2'b10, 32'h40));
    ex(t0 + 2, K_ADDR, av(3'b001, 2'b11, 32'h44));
    for (int c = 3; c <= 5; c++) ex(t0 + c, K_ADDR, av(3'b001, 2'b11, 32'h48));
    ex(t0 + 2, K_RDV, 32'hCAFE_0001);
    ex(t0 + 5, K_RDV, 32'hCAFE_0004);
    ex(t0 + 6, K_RDV, 32'hCAFE_0005);
    ex(t0 + 7, K_DONE, 0);
    wait_done();
    stall_lo = -10; stall_hi = -10;
    // 1 KB boundary crossing
    issue(0, 32'h3F8, 4'd3);
    ex(t0 + 1, K_ADDR, av(3'b001, 2'b10, 32'h3F8));
    ex(t0 + 2, K_ADDR, av(3'b001, 2'b11, 32'h3FC));
    ex(t0 + 3, K_ADDR, av(3'b001, 2'b10, 32'h400));
    ex(t0 + 4, K_ADDR, av(3'b001, 2'b11, 32'h404));
    for (int i = 0; i < 4; i++) ex(t0 + 2 + i, K_RDV, 32'hCAFE_0001 + 32'(i));
    ex(t0 + 6, K_DONE, 0);
    wait_done();
    // ERROR response on beat 1 of a 4-beat write
    err_off = 3;
    issue(1, 32'h0, 4'd3);
    ex(t0 + 1, K_ADDR, av(3'b001, 2'b10, 32'h0));
    ex(t0 + 2, K_ADDR, av(3'b001, 2'b11, 32'h4));
    ex(t0 + 3, K_ADDR, av(3'b001, 2'b00, 32'h8));
    ex(t0 + 1, K_POP, 0);
    ex(t0 + 2, K_POP, 0);
    ex(t0 + 2, K_WD, 32'hB0);
    ex(t0 + 3, K_WD, 32'hB1);
    ex(t0 + 5, K_DONE, 1);
    ex(t0 + 5, K_RDY, 0);
    wait_done();
    err_off = -10;
    // command after the aborted one
    issue(1, 32'h10, 4'd0);
    ex(t0 + 1, K_ADDR, av(3'b000, 2'b10, 32'h10));
    ex(t0 + 1, K_POP, 0);
    ex(t0 + 2, K_WD, 32'hC0);
    ex(t0 + 3, K_DONE, 0);
    wait_done();
    // reset during the data phase of beat 2
    issue(0, 32'h200, 4'd3);
    ex(t0 + 1, K_ADDR, av(3'b001, 2'b10, 32'h200));
    ex(t0 + 2, K_ADDR, av(3'b001, 2'b11, 32'h204));
    ex(t0 + 3, K_ADDR, av(3'b001, 2'b11, 32'h208));
    ex(t0 + 2, K_RDV, 32'hCAFE_0001);
    ex(t0 + 3, K_RDV, 32'hCAFE_0002);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_htrans", bus.O_HTRANS, 0);
    chk("midrst_ready", bus.O_CMD_READY, 1);
    chk("midrst_haddr", bus.O_HADDR, 0);
    chk("midrst_done_rdv", {bus.O_DONE, bus.O_RDATA_VALID}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("pending_expectations", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
